ncl_th_gate_bank: RTL and testbench

- Synchronous, clocked emulation of the NCL threshold gates TH12, TH22 and TH22N, replicated WIDTH times in parallel.
- Used where dual-rail NCL datapaths (ripple adders, input/output buffer registers, completeness trees) are mapped onto a single-clock synthesizable fabric.
- Each lane evaluates its threshold function combinationally against a registered hysteresis state.

---
 rtl/ncl_pkg.sv | 19 +
 rtl/ncl_th_gate_bank_if.sv | 11 +
 rtl/ncl_th_cell.sv | 52 +++++
 rtl/ncl_th_gate_bank.sv | 29 ++
 tb/tb_ncl_th_gate_bank.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ncl_pkg.sv
// Shared NCL gate definitions: gate-type enum and per-type threshold lookup.
package ncl_pkg;

  typedef enum logic [1:0] {
    TH12  = 2'd0,
    TH22  = 2'd1,
    TH22N = 2'd2
  } gate_type_e;

  // Returns 0 for an unsupported gate type so callers can reject it at elaboration.
  function automatic int unsigned ncl_threshold(gate_type_e gate);
    case (gate)
      TH12:        return 1;
      TH22, TH22N: return 2;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/ncl_th_gate_bank_if.sv
// Per-lane gate inputs a/b and output y for a bank of NCL threshold gates.
interface ncl_th_gate_bank_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;

  modport master (output a, output b, input  y);
  modport slave  (input  a, input  b, output y);
endinterface

// File: rtl/ncl_th_cell.sv
// Single clocked NCL threshold-gate lane: set at count >= M, NULL at count 0, else hold.
module ncl_th_cell
  import ncl_pkg::*;
#(
  parameter gate_type_e GATE_TYPE = TH22
) (
  input  logic clk,
  input  logic init,
  input  logic a,
  input  logic b,
  output logic y
);

  localparam int unsigned Thresh = ncl_threshold(GATE_TYPE);
  localparam logic [1:0]  M      = 2'(Thresh);

  if (Thresh == 0) begin : g_bad_gate
    $error("ncl_th_cell: unsupported GATE_TYPE");
  end

  logic [1:0] count;
  logic       st_q;
  logic       y_eval;

  always_comb begin
    count = {1'b0, a} + {1'b0, b};
    if (count >= M) begin
      y_eval = 1'b1;
    end else if (count == 2'd0) begin
      y_eval = 1'b0;
    end else begin
      y_eval = st_q;
    end
  end

  // Only TH22N carries a reset pin; the other gates keep evaluating during init.
  always_comb begin
    y = y_eval;
    if (GATE_TYPE == TH22N && init) begin
      y = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      st_q <= 1'b0;
    end else begin
      st_q <= y;
    end
  end

endmodule

// File: rtl/ncl_th_gate_bank.sv
// WIDTH independent clocked NCL threshold-gate lanes of one gate type.
module ncl_th_gate_bank
  import ncl_pkg::*;
#(
  parameter gate_type_e  GATE_TYPE = TH22,
  parameter int unsigned WIDTH     = 1
) (
  input logic                 clk,
  input logic                 init,
  ncl_th_gate_bank_if.slave   bus
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("ncl_th_gate_bank: WIDTH must be 1..64");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ncl_th_cell #(
      .GATE_TYPE (GATE_TYPE)
    ) u_cell (
      .clk  (clk),
      .init (init),
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .y    (bus.y[i])
    );
  end

endmodule

// File: tb/tb_ncl_th_gate_bank.sv
// Directed and reference-model checks across TH12, TH22 and TH22N gate banks.
module tb_ncl_th_gate_bank;
  import ncl_pkg::*;

  logic clk;
  logic init;
  int   vectors;
  int   miscompares;

  ncl_th_gate_bank_if #(.WIDTH(4))  if12 ();
  ncl_th_gate_bank_if #(.WIDTH(1))  if22 ();
  ncl_th_gate_bank_if #(.WIDTH(2))  if22n ();
  ncl_th_gate_bank_if #(.WIDTH(64)) if64 ();

  ncl_th_gate_bank #(.GATE_TYPE(TH12), .WIDTH(4)) u_th12 (
    .clk (clk), .init (init), .bus (if12)
  );
  ncl_th_gate_bank #(.GATE_TYPE(TH22), .WIDTH(1)) u_th22 (
    .clk (clk), .init (init), .bus (if22)
  );
  ncl_th_gate_bank #(.GATE_TYPE(TH22N), .WIDTH(2)) u_th22n (
    .clk (clk), .init (init), .bus (if22n)
  );
  ncl_th_gate_bank #(.GATE_TYPE(TH22), .WIDTH(64)) u_th22w (
    .clk (clk), .init (init), .bus (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    init = 1'b1;
    if12.a = '0;  if12.b = '0;
    if22.a = '0;  if22.b = '0;
    if22n.a = 2'b11; if22n.b = 2'b11;
    if64.a = '0;  if64.b = '0;
    step();
    #1;
    vectors++;
    if (if22n.y !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_th22n_forced: y=%b expected 00", if22n.y);
    end
    vectors++;
    if (if12.y !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_th12: y=%b expected 0000", if12.y);
    end
    init = 1'b0;
    if22.a = 1'b1;
    if64.a = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    vectors++;
    if (if22.y !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_th22_st0: y=%b expected 0", if22.y);
    end
    vectors++;
    if (if64.y !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_th22w_st0: y=%h expected 0", if64.y);
    end
    if22.a = 1'b0;
    if64.a = '0;
  endtask

  task automatic test_th12();
    step();
    if12.a = 4'b0101; if12.b = 4'b0011;
    #1;
    vectors++;
    if (if12.y !== 4'b0111) begin
      miscompares++;
      $display("FAIL th12_or: y=%b expected 0111", if12.y);
    end
    step();
    if12.a = 4'b0000; if12.b = 4'b0000;
    #1;
    vectors++;
    if (if12.y !== 4'b0000) begin
      miscompares++;
      $display("FAIL th12_null: y=%b expected 0000", if12.y);
    end
    step();
    if12.a = 4'b1010; if12.b = 4'b0000;
    init = 1'b1;
    #1;
    vectors++;
    if (if12.y !== 4'b1010) begin
      miscompares++;
      $display("FAIL th12_init_during: y=%b expected 1010", if12.y);
    end
    step();
    #1;
    vectors++;
    if (if12.y !== 4'b1010) begin
      miscompares++;
      $display("FAIL th12_init_after_edge: y=%b expected 1010", if12.y);
    end
    init = 1'b0;
  endtask

  task automatic test_th22_sequence();
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] sy;
    sa = 5'b10011;  // applied LSB first: (1,0),(1,1),(0,1),(0,0),(1,0)
    sb = 5'b00110;
    sy = 5'b00110;
    for (int k = 0; k < 5; k++) begin
      step();
      if22.a = sa[k]; if22.b = sb[k];
      #1;
      vectors++;
      if (if22.y !== sy[k]) begin
        miscompares++;
        $display("FAIL th22_seq_step%0d: y=%b expected %b", k, if22.y, sy[k]);
      end
    end
    // TH22 has no reset pin: output follows inputs during init, but state is cleared.
    step();
    if22.a = 1'b1; if22.b = 1'b1;
    init = 1'b1;
    #1;
    vectors++;
    if (if22.y !== 1'b1) begin
      miscompares++;
      $display("FAIL th22_init_not_forced: y=%b expected 1", if22.y);
    end
    step();
    init = 1'b0;
    if22.b = 1'b0;
    #1;
    vectors++;
    if (if22.y !== 1'b0) begin
      miscompares++;
      $display("FAIL th22_init_clears_st: y=%b expected 0", if22.y);
    end
    if22.a = 1'b0;
  endtask

  task automatic test_th22n_release();
    step();
    init = 1'b1;
    if22n.a = 2'b11; if22n.b = 2'b11;
    #1;
    vectors++;
    if (if22n.y !== 2'b00) begin
      miscompares++;
      $display("FAIL th22n_init_force: y=%b expected 00", if22n.y);
    end
    step();
    init = 1'b0;
    #1;
    vectors++;
    if (if22n.y !== 2'b11) begin
      miscompares++;
      $display("FAIL th22n_release_set: y=%b expected 11", if22n.y);
    end
    step();
    if22n.a = 2'b01; if22n.b = 2'b10;
    #1;
    vectors++;
    if (if22n.y !== 2'b11) begin
      miscompares++;
      $display("FAIL th22n_hold: y=%b expected 11", if22n.y);
    end
  endtask

  task automatic test_th22n_midop_reset();
    // Continues from a held 11 with mixed inputs.
    step();
    init = 1'b1;
    #1;
    vectors++;
    if (if22n.y !== 2'b00) begin
      miscompares++;
      $display("FAIL th22n_midop_during: y=%b expected 00", if22n.y);
    end
    step();
    init = 1'b0;
    #1;
    vectors++;
    if (if22n.y !== 2'b00) begin
      miscompares++;
      $display("FAIL th22n_midop_after: y=%b expected 00", if22n.y);
    end
  endtask

  task automatic test_th22n_simultaneous();
    step();
    if22n.a = 2'b11; if22n.b = 2'b11;
    #1;
    step();
    init = 1'b1;
    #1;
    vectors++;
    if (if22n.y !== 2'b00) begin
      miscompares++;
      $display("FAIL th22n_simul_force: y=%b expected 00", if22n.y);
    end
    // Mixed inputs after the init edge expose st, which must be 0 despite a=b=1 there.
    step();
    init = 1'b0;
    if22n.a = 2'b10; if22n.b = 2'b01;
    #1;
    vectors++;
    if (if22n.y !== 2'b00) begin
      miscompares++;
      $display("FAIL th22n_simul_st0: y=%b expected 00", if22n.y);
    end
    step();
    if22n.a = 2'b11; if22n.b = 2'b11;
    #1;
    vectors++;
    if (if22n.y !== 2'b11) begin
      miscompares++;
      $display("FAIL th22n_simul_resume: y=%b expected 11", if22n.y);
    end
  endtask

  task automatic test_lane_independence();
    logic [63:0] pa [3];
    logic [63:0] pb [3];
    logic [63:0] py [3];
    pa[0] = 64'h1;                   pb[0] = 64'h1;                   py[0] = 64'h1;
    pa[1] = 64'h3;                   pb[1] = 64'h2;                   py[1] = 64'h3;
    pa[2] = 64'h8000_0000_0000_0002; pb[2] = 64'h8000_0000_0000_0000; py[2] = 64'h8000_0000_0000_0002;
    for (int k = 0; k < 3; k++) begin
      step();
      if64.a = pa[k]; if64.b = pb[k];
      #1;
      vectors++;
      if (if64.y !== py[k]) begin
        miscompares++;
        $display("FAIL lanes_step%0d: y=%h expected %h", k, if64.y, py[k]);
      end
    end
  endtask

  task automatic test_th22_random64();
    logic [63:0] st;
    logic [63:0] exp;
    step();
    init = 1'b1;
    if64.a = '0; if64.b = '0;
    step();
    init = 1'b0;
    st = '0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if64.a = {$urandom, $urandom};
      if64.b = {$urandom, $urandom};
      #1;
      exp = (if64.a & if64.b) | (st & (if64.a | if64.b));
      vectors++;
      if (if64.y !== exp) begin
        miscompares++;
        $display("FAIL th22_random_cycle%0d: y=%h expected %h", k, if64.y, exp);
      end
      st = exp;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    init        = 1'b1;
    test_reset();
    test_th12();
    test_th22_sequence();
    test_th22n_release();
    test_th22n_midop_reset();
    test_th22n_simultaneous();
    test_lane_independence();
    test_th22_random64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
